spi_master_cmd_fifo: RTL and testbench
======================================

# spi_master_cmd_fifo

Write-command buffer between the SPI-slave address decode and the DUT SPI master. It captures register writes targeted at the master (address page 0x02) into a FIFO and replays them one at a time, only while the master reports idle. Back-to-back host writes are therefore not lost while a DUT SPI transfer is in flight. Level, full, empty and sticky-overflow status are readable through a local status register.

## Interface
- DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 entries (16); each entry is {waddr[7:0], wdata[15:0]}.
- GAP, 2, idle cycles inserted after each issued write before the next m_busy check (1..15).
- sys_clk  in  1  system clock; all logic is on this clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- sys_sel  in  1  page select for the master page, registered by the decode stage.
- sys_wr_en  in  1  single-cycle write strobe.
- sys_waddr  in  8  write address within the page.
- sys_wdata  in  16  write data.
- sys_rd_en  in  1  single-cycle read strobe.
- sys_raddr  in  8  read address within the page.
- sys_rdata  out  16  local status readback.
- m_sel  out  1  select to the master; high only while m_wr_en is high.
- m_wr_en  out  1  single-cycle write strobe to the master.
- m_waddr  out  8  address of the replayed write.
- m_wdata  out  16  data of the replayed write.
- m_busy  in  1  master transfer in progress; high blocks issue.

## Operation
- **Push**
  - sys_sel=1 and sys_wr_en=1 with sys_waddr != 0xF0 pushes {sys_waddr, sys_wdata}.
  - Writes with sys_sel=0 are ignored.
- **Control register 0xF0** (sys_sel=1, sys_wr_en=1)
  - Never queued.
  - wdata[0]=1 flushes: pointers and level go to 0, FSM goes to IDLE.
  - A flush does not clear overflow.
- **Status register 0xF1** (sys_sel=1, sys_rd_en=1)
  - sys_rdata = {overflow, empty, full, 8'b0, level[4:0]}. level is zero-extended to 5 bits; for DEPTH_LOG2=4 its range is 0..16.
  - A read of any other address returns 0x0000.
  - sys_rdata holds its value between reads.
  - Reading 0xF1 clears overflow on the following edge.
- **Overflow**
  - A push while full with no pop in the same cycle is dropped and sets overflow (sticky).
  - A push while full with a pop in the same cycle is accepted; level is unchanged.
  - If an overflow event and a status read occur in the same cycle, set wins: overflow stays 1.
- **Drain FSM**
  - IDLE: if !empty and m_busy=0, go to ISSUE.
  - ISSUE (1 cycle): m_wr_en=m_sel=1, m_waddr/m_wdata = FIFO head, pop; go to GAP.
  - GAP: count GAP cycles, then go to IDLE.
- **Flush priority:** a flush forces IDLE in any state. A flush in the cycle the FSM would enter ISSUE suppresses the issue.
- Push and pop in the same cycle leave level unchanged. Pointers wrap modulo depth.
- m_waddr/m_wdata are registered at entry to ISSUE and hold afterwards until the next issue.

## Timing
- **Reset values:** sys_rdata=0x0000, m_sel=0, m_wr_en=0, m_waddr=0x00, m_wdata=0x0000, level=0, overflow=0, FSM=IDLE.
- Push strobe at cycle N → level/empty update at N+1.
- With the FSM in IDLE and m_busy=0, m_wr_en is high during N+2. Push-to-issue latency is 2 cycles.
- Status read strobe at N → sys_rdata valid at N+1, reflecting state sampled at N.
- Minimum issue spacing is GAP+2 cycles (ISSUE + GAP + IDLE). m_busy is sampled in IDLE only.
- Async reset during ISSUE drops m_wr_en immediately and discards all entries.

## Test plan
- Single write: push addr 0x12 data 0xBEEF with m_busy=0 → at N+2 m_wr_en=m_sel=1 for exactly 1 cycle, m_waddr=0x12, m_wdata=0xBEEF; status read then returns 0x4000.
- Busy blocking: push 3 entries with m_busy=1 held for 50 cycles → no m_wr_en. Release m_busy → 3 strobes in order, spaced 4 cycles apart (GAP=2).
- Full/overflow: with m_busy=1, push 17 entries → status 0xA010. Read again → 0x2010 (overflow cleared). Release m_busy → 16 writes replayed in order; the 17th is absent.
- Full with simultaneous push/pop: fill 16, release m_busy, push in the same cycle as ISSUE → accepted, overflow stays 0, level stays 16 that cycle.
- Flush: queue 5 entries with m_busy=1, write 0xF0 ← 0x0001 → status 0x4000. Release m_busy → no m_wr_en.
- Reset mid-drain: assert sys_rst_n=0 during ISSUE → m_wr_en drops asynchronously, all outputs take reset values, status 0x4000 after release.

Source files
------------

// File: rtl/spi_master_cmd_fifo.sv
// Write-command FIFO for the master register page: queues host writes and
// replays them one at a time whenever the SPI master reports idle.
module spi_master_cmd_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP        = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        sys_sel,
    input  logic        sys_wr_en,
    input  logic [7:0]  sys_waddr,
    input  logic [15:0] sys_wdata,
    input  logic        sys_rd_en,
    input  logic [7:0]  sys_raddr,
    output logic [15:0] sys_rdata,
    output logic        m_sel,
    output logic        m_wr_en,
    output logic [7:0]  m_waddr,
    output logic [15:0] m_wdata,
    input  logic        m_busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } entry_t;

    entry_t                r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_ovf;
    logic [15:0]           r_rdata;
    state_t                r_state;
    logic [3:0]            r_gap_cnt;
    logic                  r_m_wr_en, r_m_sel;
    logic [7:0]            r_m_waddr;
    logic [15:0]           r_m_wdata;

    logic       w_wr, w_ctrl, w_flush, w_push_req, w_push, w_pop;
    logic       w_empty, w_full, w_ovf_evt, w_rd, w_stat_rd;
    logic [4:0] w_level5;
    entry_t     w_head;

    assign w_wr       = sys_sel && sys_wr_en;
    assign w_ctrl     = w_wr && (sys_waddr == 8'hF0);
    assign w_flush    = w_ctrl && sys_wdata[0];
    assign w_push_req = w_wr && !w_ctrl;
    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == FULL_LVL);
    // Pop happens during the ISSUE cycle; head was already latched on entry.
    assign w_pop      = (r_state == S_ISSUE);
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_evt  = w_push_req && w_full && !w_pop;
    assign w_rd       = sys_sel && sys_rd_en;
    assign w_stat_rd  = w_rd && (sys_raddr == 8'hF1);
    assign w_level5   = 5'(r_level);
    assign w_head     = r_mem[r_rptr];

    always_ff @(posedge sys_clk) begin
        if (w_push) r_mem[r_wptr] <= '{addr: sys_waddr, data: sys_wdata};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (w_pop && !w_push) r_level <= r_level - 1'b1;
        end
    end

    // Overflow set has priority over the read-clear; flush leaves it alone.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)     r_ovf <= 1'b0;
        else if (w_ovf_evt) r_ovf <= 1'b1;
        else if (w_stat_rd) r_ovf <= 1'b0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_rdata <= '0;
        else if (w_rd)  r_rdata <= w_stat_rd ? {r_ovf, w_empty, w_full, 8'b0, w_level5} : 16'h0000;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
            r_m_wr_en <= 1'b0;
            r_m_sel   <= 1'b0;
            r_m_waddr <= '0;
            r_m_wdata <= '0;
        end else begin
            r_m_wr_en <= 1'b0;
            r_m_sel   <= 1'b0;
            if (w_flush) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: if (!w_empty && !m_busy) begin
                        r_state   <= S_ISSUE;
                        r_m_wr_en <= 1'b1;
                        r_m_sel   <= 1'b1;
                        r_m_waddr <= w_head.addr;
                        r_m_wdata <= w_head.data;
                    end
                    S_ISSUE: begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= '0;
                    end
                    S_GAP: begin
                        if (r_gap_cnt == GAP_LAST) r_state <= S_IDLE;
                        else r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign sys_rdata = r_rdata;
    assign m_sel     = r_m_sel;
    assign m_wr_en   = r_m_wr_en;
    assign m_waddr   = r_m_waddr;
    assign m_wdata   = r_m_wdata;
endmodule

// File: tb/tb_spi_master_cmd_fifo.sv
// Directed bench for spi_master_cmd_fifo: push/issue timing, busy gating,
// overflow, flush and asynchronous reset during an issue.
module tb_spi_master_cmd_fifo;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        sys_sel = 1'b0, sys_wr_en = 1'b0, sys_rd_en = 1'b0;
    logic [7:0]  sys_waddr = '0, sys_raddr = '0;
    logic [15:0] sys_wdata = '0;
    logic [15:0] sys_rdata;
    logic        m_sel, m_wr_en, m_busy = 1'b0;
    logic [7:0]  m_waddr;
    logic [15:0] m_wdata;

    int checks = 0;
    int errors = 0;
    logic [7:0]  cap_a[$];
    logic [15:0] cap_d[$];
    int          cap_t[$];
    int          sel_bad;

    spi_master_cmd_fifo #(.DEPTH_LOG2(4), .GAP(2)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sys_sel(sys_sel),
        .sys_wr_en(sys_wr_en), .sys_waddr(sys_waddr), .sys_wdata(sys_wdata),
        .sys_rd_en(sys_rd_en), .sys_raddr(sys_raddr), .sys_rdata(sys_rdata),
        .m_sel(m_sel), .m_wr_en(m_wr_en), .m_waddr(m_waddr), .m_wdata(m_wdata),
        .m_busy(m_busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        sys_sel = 1'b1; sys_wr_en = 1'b1; sys_waddr = a; sys_wdata = d;
        step();
        sys_sel = 1'b0; sys_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [15:0] d);
        sys_sel = 1'b1; sys_rd_en = 1'b1; sys_raddr = a;
        step();
        sys_sel = 1'b0; sys_rd_en = 1'b0;
        d = sys_rdata;
    endtask

    task automatic collect(input int ncyc);
        cap_a.delete(); cap_d.delete(); cap_t.delete(); sel_bad = 0;
        for (int c = 0; c < ncyc; c++) begin
            step();
            if (m_sel !== m_wr_en) sel_bad++;
            if (m_wr_en === 1'b1) begin
                cap_a.push_back(m_waddr); cap_d.push_back(m_wdata); cap_t.push_back(c);
            end
        end
    endtask

    task automatic wait_wr(input int max, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max && !ok; c++) begin
            step();
            if (m_wr_en === 1'b1) ok = 1'b1;
        end
    endtask

    initial begin
        logic [15:0] s;
        bit ok;

        // Reset values
        repeat (3) step();
        chk("rst_rdata", 32'(sys_rdata), 32'h0000);
        chk("rst_wr_en", 32'(m_wr_en), 32'h0);
        chk("rst_sel", 32'(m_sel), 32'h0);
        chk("rst_waddr", 32'(m_waddr), 32'h00);
        chk("rst_wdata", 32'(m_wdata), 32'h0000);
        sys_rst_n = 1'b1;
        step();
        rd(8'hF1, s); chk("rst_status", 32'(s), 32'h4000);

        // Single write: issue two cycles after the push strobe
        wr(8'h12, 16'hBEEF);
        chk("single_n1_wr_en", 32'(m_wr_en), 32'h0);
        rd(8'hF1, s);
        chk("single_n1_level", 32'(s), 32'h0001);
        chk("single_n2_wr_en", 32'(m_wr_en), 32'h1);
        chk("single_n2_sel", 32'(m_sel), 32'h1);
        chk("single_n2_waddr", 32'(m_waddr), 32'h12);
        chk("single_n2_wdata", 32'(m_wdata), 32'hBEEF);
        step();
        chk("single_n3_wr_en", 32'(m_wr_en), 32'h0);
        chk("single_n3_hold", 32'(m_waddr), 32'h12);
        repeat (4) step();
        rd(8'hF1, s); chk("single_status", 32'(s), 32'h4000);

        // Ignored write, non-status read, rdata hold
        m_busy = 1'b1;
        sys_sel = 1'b0; sys_wr_en = 1'b1; sys_waddr = 8'h33; sys_wdata = 16'h1234;
        step();
        sys_wr_en = 1'b0;
        rd(8'hF1, s); chk("nosel_status", 32'(s), 32'h4000);
        repeat (3) step();
        chk("rdata_hold", 32'(sys_rdata), 32'h4000);
        rd(8'h10, s); chk("other_addr", 32'(s), 32'h0000);

        // Busy blocking, then ordered replay at GAP+2 spacing
        wr(8'hA1, 16'h0101); wr(8'hA2, 16'h0202); wr(8'hA3, 16'h0303);
        collect(50);
        chk("busy_no_issue", 32'(cap_a.size()), 32'd0);
        rd(8'hF1, s); chk("busy_level", 32'(s), 32'h0003);
        m_busy = 1'b0;
        collect(20);
        chk("busy_count", 32'(cap_a.size()), 32'd3);
        chk("busy_sel", 32'(sel_bad), 32'd0);
        if (cap_a.size() == 3) begin
            chk("busy_a0", 32'({cap_a[0], cap_d[0]}), 32'hA10101);
            chk("busy_a1", 32'({cap_a[1], cap_d[1]}), 32'hA20202);
            chk("busy_a2", 32'({cap_a[2], cap_d[2]}), 32'hA30303);
            chk("busy_sp1", 32'(cap_t[1] - cap_t[0]), 32'd4);
            chk("busy_sp2", 32'(cap_t[2] - cap_t[1]), 32'd4);
        end

        // Overflow: 17th push coincides with a status read; set wins
        m_busy = 1'b1;
        for (int i = 0; i < 16; i++) wr(8'(8'h20 + i), 16'(16'h1000 + i));
        sys_sel = 1'b1; sys_wr_en = 1'b1; sys_waddr = 8'h30; sys_wdata = 16'h1010;
        sys_rd_en = 1'b1; sys_raddr = 8'hF1;
        step();
        sys_sel = 1'b0; sys_wr_en = 1'b0; sys_rd_en = 1'b0;
        chk("ovf_pre", 32'(sys_rdata), 32'h2010);
        rd(8'hF1, s); chk("ovf_set", 32'(s), 32'hA010);
        rd(8'hF1, s); chk("ovf_clr", 32'(s), 32'h2010);
        m_busy = 1'b0;
        collect(80);
        chk("ovf_count", 32'(cap_a.size()), 32'd16);
        for (int i = 0; i < cap_a.size() && i < 16; i++)
            chk($sformatf("ovf_e%0d", i), 32'({cap_a[i], cap_d[i]}),
                32'({8'(8'h20 + i), 16'(16'h1000 + i)}));

        // Full with push in the same cycle as ISSUE
        m_busy = 1'b1;
        for (int i = 0; i < 16; i++) wr(8'(8'h40 + i), 16'(16'h2000 + i));
        rd(8'hF1, s); chk("pp_full", 32'(s), 32'h2010);
        m_busy = 1'b0;
        wait_wr(10, ok);
        chk("pp_issue_seen", 32'(ok), 32'h1);
        chk("pp_head", 32'(m_waddr), 32'h40);
        wr(8'h99, 16'h5555);
        rd(8'hF1, s); chk("pp_level", 32'(s), 32'h2010);
        collect(80);
        chk("pp_count", 32'(cap_a.size()), 32'd16);
        if (cap_a.size() == 16) begin
            chk("pp_first", 32'({cap_a[0], cap_d[0]}), 32'h412001);
            chk("pp_last", 32'({cap_a[15], cap_d[15]}), 32'h995555);
        end
        rd(8'hF1, s); chk("pp_empty", 32'(s), 32'h4000);

        // Flush discards queued entries
        m_busy = 1'b1;
        for (int i = 0; i < 5; i++) wr(8'(8'h60 + i), 16'h0);
        wr(8'hF0, 16'h0001);
        rd(8'hF1, s); chk("flush_status", 32'(s), 32'h4000);
        m_busy = 1'b0;
        collect(20);
        chk("flush_no_issue", 32'(cap_a.size()), 32'd0);

        // Flush preserves overflow
        m_busy = 1'b1;
        for (int i = 0; i < 17; i++) wr(8'(8'h70 + i), 16'h0);
        wr(8'hF0, 16'h0001);
        rd(8'hF1, s); chk("flush_keep_ovf", 32'(s), 32'hC000);
        rd(8'hF1, s); chk("flush_ovf_clr", 32'(s), 32'h4000);

        // Async reset during ISSUE
        for (int i = 0; i < 3; i++) wr(8'(8'h80 + i), 16'hAAAA);
        m_busy = 1'b0;
        wait_wr(10, ok);
        chk("rstmid_issue_seen", 32'(ok), 32'h1);
        sys_rst_n = 1'b0;
        #1;
        chk("rstmid_wr_en", 32'(m_wr_en), 32'h0);
        chk("rstmid_sel", 32'(m_sel), 32'h0);
        chk("rstmid_waddr", 32'(m_waddr), 32'h00);
        chk("rstmid_wdata", 32'(m_wdata), 32'h0000);
        step();
        sys_rst_n = 1'b1;
        collect(20);
        chk("rstmid_no_issue", 32'(cap_a.size()), 32'd0);
        rd(8'hF1, s); chk("rstmid_status", 32'(s), 32'h4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
